// File: rtl/calc1_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | calc1_pkg                                                              |
// | Shared codes and slice helpers for the calc1 scoreboard.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE     = 2'd0,
        RESP_OK       = 2'd1,
        RESP_OVERFLOW = 2'd2,
        RESP_INVALID  = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        VIOL_NONE       = 2'd0,
        VIOL_UNEXPECTED = 2'd1,
        VIOL_OVERFLOW   = 2'd2,
        VIOL_TIMEOUT    = 2'd3
    } viol_e;

    // Bit positions inside a per-port violation request vector.
    localparam int VREQ_UNEXPECTED = 0;
    localparam int VREQ_OVERFLOW   = 1;
    localparam int VREQ_TIMEOUT    = 2;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc1_scoreboard_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | calc1_scoreboard_if                                                    |
// | Snooped command/response bus seen by the calc1 scoreboard.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface calc1_scoreboard_if #(
    parameter int NPORTS = 4
);
    logic [4*NPORTS-1:0] req_cmd_in;
    logic [2*NPORTS-1:0] out_resp;

    modport master (
        output req_cmd_in,
        output out_resp
    );

    modport slave (
        input req_cmd_in,
        input out_resp
    );
endinterface
`default_nettype wire

// File: rtl/calc1_sb_port_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | calc1_sb_port_tracker                                                  |
// | One port: issue-timestamp FIFO, counters, worst latency, violations.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module calc1_sb_port_tracker
    import calc1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TS_W    = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic [3:0]       cmd,
    input  wire logic [1:0]       resp,
    input  wire logic [TS_W-1:0]  now,
    output logic      [CNT_W-1:0] issued_cnt,
    output logic      [CNT_W-1:0] done_cnt,
    output logic      [CNT_W-1:0] err_cnt,
    output logic      [TS_W-1:0]  max_lat,
    output logic      [2:0]       viol_req
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             r_reported;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [TS_W-1:0]  r_max_lat;

    logic             w_cmd_v;
    logic             w_resp_v;
    logic             w_err_code;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [TS_W-1:0]  w_head;
    logic [TS_W-1:0]  w_age;
    logic             w_timeout;

    assign w_cmd_v    = (cmd != CMD_NONE);
    assign w_resp_v   = (resp != RESP_NONE);
    assign w_err_code = (resp == RESP_OVERFLOW) || (resp == RESP_INVALID);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // Pop is resolved first so a response frees a slot for a same-cycle issue.
    assign w_pop  = w_resp_v && !w_empty;
    assign w_push = w_cmd_v && (!w_full || w_pop);

    assign w_head    = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_age     = now - w_head;
    assign w_timeout = !w_empty && !r_reported && (w_age >= TS_W'(TIMEOUT));

    always_comb begin
        viol_req                  = '0;
        viol_req[VREQ_UNEXPECTED] = w_resp_v && w_empty;
        viol_req[VREQ_OVERFLOW]   = w_cmd_v && w_full && !w_pop;
        viol_req[VREQ_TIMEOUT]    = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_reported   <= 1'b0;
            r_issued_cnt <= '0;
            r_done_cnt   <= '0;
            r_err_cnt    <= '0;
            r_max_lat    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // The reported flag belongs to the current head entry only.
            if (w_pop) begin
                r_reported <= 1'b0;
            end else if (w_timeout) begin
                r_reported <= 1'b1;
            end

            if (clr) begin
                r_issued_cnt <= '0;
                r_done_cnt   <= '0;
                r_err_cnt    <= '0;
                r_max_lat    <= '0;
            end else begin
                if (w_cmd_v && !(&r_issued_cnt)) begin
                    r_issued_cnt <= r_issued_cnt + 1'b1;
                end
                if (w_pop) begin
                    if (!(&r_done_cnt)) begin
                        r_done_cnt <= r_done_cnt + 1'b1;
                    end
                    if (w_err_code && !(&r_err_cnt)) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (w_age > r_max_lat) begin
                        r_max_lat <= w_age;
                    end
                end
            end
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign done_cnt   = r_done_cnt;
    assign err_cnt    = r_err_cnt;
    assign max_lat    = r_max_lat;

endmodule
`default_nettype wire

// File: rtl/calc1_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | calc1_scoreboard                                                       |
// | Passive scoreboard: per-port latency/outstanding tracking + violations.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module calc1_scoreboard
    import calc1_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int DEPTH   = 4,
    parameter int TS_W    = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic                    c_clk,
    input  wire logic                    reset,
    calc1_scoreboard_if.slave            bus,
    input  wire logic                    clr,
    output logic [CNT_W*NPORTS-1:0]      issued_cnt,
    output logic [CNT_W*NPORTS-1:0]      done_cnt,
    output logic [CNT_W*NPORTS-1:0]      err_cnt,
    output logic [TS_W*NPORTS-1:0]       max_lat,
    output logic                         violation,
    output logic [1:0]                   viol_code,
    output logic [1:0]                   viol_port
);

    logic [TS_W-1:0]         r_ts;
    logic [NPORTS-1:0][2:0]  w_viol_req;

    logic                    w_hit;
    viol_e                   w_hit_code;
    logic [1:0]              w_hit_port;

    logic                    r_violation;
    logic [1:0]              r_viol_code;
    logic [1:0]              r_viol_port;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            calc1_sb_port_tracker #(
                .DEPTH   (DEPTH),
                .TS_W    (TS_W),
                .CNT_W   (CNT_W),
                .TIMEOUT (TIMEOUT)
            ) u_tracker (
                .clk        (c_clk),
                .rst_n      (reset),
                .clr        (clr),
                .cmd        (bus.req_cmd_in[slice_lo(p, CMD_W) +: CMD_W]),
                .resp       (bus.out_resp[slice_lo(p, RESP_W) +: RESP_W]),
                .now        (r_ts),
                .issued_cnt (issued_cnt[slice_lo(p, CNT_W) +: CNT_W]),
                .done_cnt   (done_cnt[slice_lo(p, CNT_W) +: CNT_W]),
                .err_cnt    (err_cnt[slice_lo(p, CNT_W) +: CNT_W]),
                .max_lat    (max_lat[slice_lo(p, TS_W) +: TS_W]),
                .viol_req   (w_viol_req[p])
            );
        end
    endgenerate

    // Lowest port wins; within a port the code order is unexpected, overflow, timeout.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_code = VIOL_NONE;
        w_hit_port = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (!w_hit) begin
                if (w_viol_req[p][VREQ_UNEXPECTED]) begin
                    w_hit      = 1'b1;
                    w_hit_code = VIOL_UNEXPECTED;
                    w_hit_port = 2'(p);
                end else if (w_viol_req[p][VREQ_OVERFLOW]) begin
                    w_hit      = 1'b1;
                    w_hit_code = VIOL_OVERFLOW;
                    w_hit_port = 2'(p);
                end else if (w_viol_req[p][VREQ_TIMEOUT]) begin
                    w_hit      = 1'b1;
                    w_hit_code = VIOL_TIMEOUT;
                    w_hit_port = 2'(p);
                end
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_violation <= 1'b0;
            r_viol_code <= VIOL_NONE;
            r_viol_port <= '0;
        end else if (clr) begin
            r_violation <= 1'b0;
            r_viol_code <= VIOL_NONE;
            r_viol_port <= '0;
        end else if (!r_violation && w_hit) begin
            r_violation <= 1'b1;
            r_viol_code <= w_hit_code;
            r_viol_port <= w_hit_port;
        end
    end

    assign violation = r_violation;
    assign viol_code = r_viol_code;
    assign viol_port = r_viol_port;

endmodule
`default_nettype wire

// File: tb/tb_calc1_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_calc1_scoreboard                                                    |
// | Directed plan steps plus random traffic against a queue-based model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_calc1_scoreboard;
    import calc1_pkg::*;

    localparam int NPORTS  = 4;
    localparam int DEPTH   = 4;
    localparam int TS_W    = 16;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    logic clr   = 1'b0;
    logic [3:0] cmd_v  [NPORTS];
    logic [1:0] resp_v [NPORTS];

    logic [CNT_W*NPORTS-1:0] issued_cnt;
    logic [CNT_W*NPORTS-1:0] done_cnt;
    logic [CNT_W*NPORTS-1:0] err_cnt;
    logic [TS_W*NPORTS-1:0]  max_lat;
    logic                    violation;
    logic [1:0]              viol_code;
    logic [1:0]              viol_port;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_q [NPORTS][$];
    bit          m_rep    [NPORTS];
    int unsigned m_issued [NPORTS];
    int unsigned m_done   [NPORTS];
    int unsigned m_err    [NPORTS];
    int unsigned m_max    [NPORTS];
    bit          m_viol;
    int unsigned m_code;
    int unsigned m_port;
    int unsigned m_ts;

    calc1_scoreboard_if #(.NPORTS(NPORTS)) bus ();

    always_comb begin
        bus.req_cmd_in = '0;
        bus.out_resp   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            bus.req_cmd_in[p*4 +: 4] = cmd_v[p];
            bus.out_resp[p*2 +: 2]   = resp_v[p];
        end
    end

    calc1_scoreboard #(
        .NPORTS  (NPORTS),
        .DEPTH   (DEPTH),
        .TS_W    (TS_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .bus        (bus),
        .clr        (clr),
        .issued_cnt (issued_cnt),
        .done_cnt   (done_cnt),
        .err_cnt    (err_cnt),
        .max_lat    (max_lat),
        .violation  (violation),
        .viol_code  (viol_code),
        .viol_port  (viol_port)
    );

    always #5 c_clk = ~c_clk;

    function automatic logic [31:0] issued_of(input int p);
        return 32'(issued_cnt[p*CNT_W +: CNT_W]);
    endfunction
    function automatic logic [31:0] done_of(input int p);
        return 32'(done_cnt[p*CNT_W +: CNT_W]);
    endfunction
    function automatic logic [31:0] err_of(input int p);
        return 32'(err_cnt[p*CNT_W +: CNT_W]);
    endfunction
    function automatic logic [31:0] lat_of(input int p);
        return 32'(max_lat[p*TS_W +: TS_W]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NPORTS; p++) begin
            m_q[p].delete();
            m_rep[p]    = 1'b0;
            m_issued[p] = 0;
            m_done[p]   = 0;
            m_err[p]    = 0;
            m_max[p]    = 0;
        end
        m_viol = 1'b0;
        m_code = 0;
        m_port = 0;
        m_ts   = 0;
    endtask

    // One clock edge of scoreboard behaviour, from the rules in plain terms.
    task automatic model_step();
        bit          found;
        int unsigned fcode;
        int unsigned fport;
        found = 1'b0;
        fcode = 0;
        fport = 0;
        for (int p = 0; p < NPORTS; p++) begin
            int unsigned sz;
            int unsigned age;
            bit has_cmd, has_resp, unexp, pop, ovf, tmo;
            sz       = m_q[p].size();
            has_cmd  = (cmd_v[p] != 0);
            has_resp = (resp_v[p] != 0);
            age      = (sz > 0) ? ((m_ts - m_q[p][0]) & 32'hFFFF) : 0;
            unexp    = has_resp && (sz == 0);
            pop      = has_resp && (sz > 0);
            ovf      = has_cmd && (sz == DEPTH) && !pop;
            tmo      = (sz > 0) && !m_rep[p] && (age >= TIMEOUT);
            if (!found) begin
                if (unexp)     begin found = 1'b1; fcode = 1; fport = p; end
                else if (ovf)  begin found = 1'b1; fcode = 2; fport = p; end
                else if (tmo)  begin found = 1'b1; fcode = 3; fport = p; end
            end
            if (pop) begin
                void'(m_q[p].pop_front());
                m_rep[p] = 1'b0;
            end else if (tmo) begin
                m_rep[p] = 1'b1;
            end
            if (has_cmd && !ovf) m_q[p].push_back(m_ts);
            if (clr) begin
                m_issued[p] = 0;
                m_done[p]   = 0;
                m_err[p]    = 0;
                m_max[p]    = 0;
            end else begin
                if (has_cmd && m_issued[p] < 65535) m_issued[p]++;
                if (pop) begin
                    if (m_done[p] < 65535) m_done[p]++;
                    if (resp_v[p] >= 2 && m_err[p] < 65535) m_err[p]++;
                    if (age > m_max[p]) m_max[p] = age;
                end
            end
        end
        if (clr) begin
            m_viol = 1'b0;
            m_code = 0;
            m_port = 0;
        end else if (!m_viol && found) begin
            m_viol = 1'b1;
            m_code = fcode;
            m_port = fport;
        end
        m_ts = (m_ts + 1) & 32'hFFFF;
    endtask

    task automatic compare_all();
        for (int p = 0; p < NPORTS; p++) begin
            chk($sformatf("issued_cnt[%0d]", p), issued_of(p), m_issued[p]);
            chk($sformatf("done_cnt[%0d]", p),   done_of(p),   m_done[p]);
            chk($sformatf("err_cnt[%0d]", p),    err_of(p),    m_err[p]);
            chk($sformatf("max_lat[%0d]", p),    lat_of(p),    m_max[p]);
        end
        chk("violation", 32'(violation), 32'(m_viol));
        chk("viol_code", 32'(viol_code), m_code);
        chk("viol_port", 32'(viol_port), m_port);
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NPORTS; p++) begin
            cmd_v[p]  = '0;
            resp_v[p] = '0;
        end
        clr = 1'b0;
    endtask

    // Inputs are held across the edge, the model consumes them, then they drop.
    task automatic tick();
        @(posedge c_clk);
        #1;
        model_step();
        clear_inputs();
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [3:0] cmd_codes [4];

    initial begin
        cmd_codes[0] = CMD_ADD;
        cmd_codes[1] = CMD_SUB;
        cmd_codes[2] = CMD_SHL;
        cmd_codes[3] = CMD_SHR;
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge c_clk);
        #1;
        compare_all();
        chk("reset_violation", 32'(violation), 0);
        chk("reset_issued0", issued_of(0), 0);
        reset = 1'b1;

        // Single add on port index 0, operand cycle, response 4 cycles after issue.
        cmd_v[0] = CMD_ADD;
        tick();
        idle(3);
        resp_v[0] = RESP_OK;
        tick();
        chk("t1_issued", issued_of(0), 1);
        chk("t1_done", done_of(0), 1);
        chk("t1_err", err_of(0), 0);
        chk("t1_lat", lat_of(0), 4);
        chk("t1_viol", 32'(violation), 0);

        // All ports issue together, responses staggered at 3/5/7/9 cycles.
        clr = 1'b1;
        tick();
        for (int p = 0; p < NPORTS; p++) cmd_v[p] = CMD_SUB;
        tick();
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) resp_v[0] = RESP_OK;
            if (k == 5) resp_v[1] = RESP_OK;
            if (k == 7) resp_v[2] = RESP_OK;
            if (k == 9) resp_v[3] = RESP_OK;
            tick();
        end
        chk("t2_lat0", lat_of(0), 3);
        chk("t2_lat1", lat_of(1), 5);
        chk("t2_lat2", lat_of(2), 7);
        chk("t2_lat3", lat_of(3), 9);
        for (int p = 0; p < NPORTS; p++) chk($sformatf("t2_done%0d", p), done_of(p), 1);

        // Response with nothing outstanding.
        clr = 1'b1;
        tick();
        resp_v[1] = RESP_OVERFLOW;
        tick();
        chk("t3_viol", 32'(violation), 1);
        chk("t3_code", 32'(viol_code), 1);
        chk("t3_port", 32'(viol_port), 1);
        chk("t3_done", done_of(1), 0);
        chk("t3_err", err_of(1), 0);

        // Overflow on the fifth issue, later timeout must not replace it.
        clr = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_v[2] = CMD_SHL;
            tick();
        end
        chk("t4_code", 32'(viol_code), 2);
        chk("t4_port", 32'(viol_port), 2);
        chk("t4_issued", issued_of(2), 5);
        idle(TIMEOUT + 6);
        chk("t4_code_held", 32'(viol_code), 2);
        chk("t4_viol_held", 32'(violation), 1);
        for (int i = 0; i < DEPTH; i++) begin
            resp_v[2] = RESP_OK;
            tick();
        end

        // Starvation: violation appears exactly at age TIMEOUT.
        clr = 1'b1;
        tick();
        cmd_v[3] = CMD_SHR;
        tick();
        idle(TIMEOUT - 1);
        chk("t5_no_viol_yet", 32'(violation), 0);
        tick();
        chk("t5_viol", 32'(violation), 1);
        chk("t5_code", 32'(viol_code), 3);
        chk("t5_port", 32'(viol_port), 3);
        clr = 1'b1;
        tick();
        resp_v[3] = RESP_INVALID;
        tick();
        chk("t5_done", done_of(3), 1);
        chk("t5_err", err_of(3), 1);
        chk("t5_viol_after", 32'(violation), 0);

        // Asynchronous reset with two commands outstanding on port index 0.
        cmd_v[0] = CMD_ADD;
        tick();
        cmd_v[0] = CMD_SHL;
        tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_issued_rst", issued_of(0), 0);
        chk("t6_viol_rst", 32'(violation), 0);
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        resp_v[0] = RESP_OK;
        tick();
        chk("t6_viol", 32'(violation), 1);
        chk("t6_code", 32'(viol_code), 1);
        chk("t6_port", 32'(viol_port), 0);

        // Random traffic against the model.
        clr = 1'b1;
        tick();
        for (int i = 0; i < 800; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                cmd_v[p]  = ($urandom_range(0, 9) < 3) ? cmd_codes[$urandom_range(0, 3)] : 4'd0;
                resp_v[p] = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
            end
            clr = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
